// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
package serial_adder_pkg;

  // Controller states; 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed for a counter that must represent 0..w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/half_adder_behavioural.sv
// One-bit half adder described behaviourally.
module half_adder_behavioural (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl_fa_cell.sv
// One-bit full adder: two half adders with their carries merged by an OR gate.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  half_adder_behavioural u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  half_adder_behavioural u_ha1 (
    .a (s0),
    .b (ci),
    .s (s),
    .c (c1)
  );

  assign co = c0 | c1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: sequences one full-adder cell over WIDTH
// cycles, LSB first, behind a start/done handshake.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;
  logic [WIDTH-1:0] sum_shift;

  fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Next-state decode and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // New result bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
  // Shifting rather than slicing keeps WIDTH=1 legal.
  always_comb begin
    sum_shift            = sum >> 1;
    sum_shift[WIDTH-1]   = fa_s;
  end

  // State register plus operand, carry, counter and result registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values, matching real flops.
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          carry <= fa_co;
          sum   <= sum_shift;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CW'(1);
          if (last_bit) cout <= fa_co;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder controller. It adds two WIDTH-bit operands by reusing one 1-bit full-adder cell over WIDTH clock cycles, processing the LSB first. The cell is built from two half_adder_behavioural instances plus an OR gate. The block sits between a requester (start/done handshake) and the 1-bit adder datapath, sequencing operand shift, carry feedback and result assembly.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 1..32)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request pulse/level; sampled only in IDLE
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
busy  output  1  high while additions are in progress (RUN state)
done  output  1  one-cycle pulse: sum/cout valid
sum  output  WIDTH  result register
cout  output  1  final carry-out

Behaviour:
- Reset: rst=1 at a rising edge -> state=IDLE; busy=0, done=0, sum=0, cout=0; shift regs, carry and counter cleared. Reset mid-RUN aborts the operation with no done pulse.
- States:
  - IDLE: start=1 -> load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, go to RUN.
  - RUN: each edge: bit = a_sh[0]^b_sh[0]^carry; carry <= full-adder carry; sum <= {bit, sum[WIDTH-1:1]}; a_sh, b_sh shift right by 1; cnt++. When cnt==WIDTH-1 at an edge, go to DONE.
  - DONE: done=1 for exactly one cycle; cout = carry. Always go to IDLE.
- Timing: start sampled at edge 0 -> bit i processed at edge i+1 -> state=DONE after edge WIDTH. done is high in the cycle between edges WIDTH and WIDTH+1. Latency from start edge to done = WIDTH+1 cycles. Minimum start-to-start spacing = WIDTH+2 cycles.
- busy = (state==RUN). done = (state==DONE). They are mutually exclusive.
- sum/cout are valid during the done cycle and hold in IDLE until the next accepted start. sum changes during RUN; its value there is undefined for consumers.
- start is ignored in RUN and DONE; there is no queueing. If start is held high continuously, a new operation begins in the cycle after done, using operand values at that edge.
- cout is updated only on the RUN->DONE transition (registered from carry) and holds otherwise.
- Width rules: result is modulo 2^WIDTH plus cout. cnt width = $clog2(WIDTH+1). WIDTH=1 runs one RUN cycle.
- a/b/cin changes after capture have no effect.

Decomposition:
- Package serial_adder_pkg: state typedef (IDLE, RUN, DONE; 2-bit encoding) and the count-width function/constant.
- Sub-module fa_cell (a, b, ci -> s, co), built from two half_adder_behavioural instances and an OR gate. It is the only datapath element. The controller holds all registers.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, cin=0, start pulse -> busy high 8 cycles; done at cycle 9 after start edge; sum=0x8D, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start pulse during RUN with different operands -> ignored; original result delivered and exactly one done pulse.
- rst asserted at RUN cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0. No done follows; a subsequent start with a=0x10, b=0x20 -> sum=0x30.
- start held high for 30 cycles with a=0x01, b=0x02 -> done pulses every 10 cycles, each with sum=0x03, cout=0. busy low only in DONE/IDLE cycles.
- WIDTH=1 build: a=1, b=1, cin=1 -> one busy cycle; done on the 2nd edge; sum=1, cout=1.
